// File: rtl/nn_layer_seq.sv
// rtl/nn_layer_seq.sv - layer sequencer and activation stage for the 1->16->16->1 datapath
// Optional leaky ReLU activation when NN_LEAKY_RELU_EN is defined.
module nn_layer_seq #(
  parameter int SETTLE_CYCLES = 1,
  parameter int W = 16,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic [2:0]     layer,
  output logic [W-1:0]   sample,
  input  logic [N*W-1:0] mat_in_vec,
  output logic [N*W-1:0] l1_vec,
  output logic [N*W-1:0] l2_vec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           busy
);

  typedef enum logic [2:0] {S_IDLE, S_L0, S_L1, S_L2, S_OUT} state_t;

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       term;
  logic       active;

  assign term   = (cnt == 4'(SETTLE_CYCLES - 1));
  assign active = (state == S_L0) || (state == S_L1) || (state == S_L2);

  function automatic logic [W-1:0] act(input logic [W-1:0] x);
`ifdef NN_LEAKY_RELU_EN
    act = x[W-1] ? W'($signed(x) >>> 3) : x;
`else
    act = x[W-1] ? '0 : x;
`endif
  endfunction

  function automatic logic [N*W-1:0] act_vec(input logic [N*W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = act(v[i*W +: W]);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      // Counter restarts on every state change so each layer gets a full settle window
      cnt   <= (state_next != state || !active) ? 4'd0 : cnt + 4'd1;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    layer      = 3'd7;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = S_L0;
      end
      S_L0: begin
        layer = 3'd0;
        if (term) state_next = S_L1;
      end
      S_L1: begin
        layer = 3'd1;
        if (term) state_next = S_L2;
      end
      S_L2: begin
        layer = 3'd2;
        if (term) state_next = S_OUT;
      end
      S_OUT: begin
        if (out_valid && out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample    <= '0;
      l1_vec    <= '0;
      l2_vec    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) sample <= in_data;
        S_L0:   if (term) l1_vec <= act_vec(mat_in_vec);
        S_L1:   if (term) l2_vec <= act_vec(mat_in_vec);
        S_L2: begin
          // Output layer is linear: element 0 is passed through unrectified
          if (term) begin
            out_data  <= mat_in_vec[W-1:0];
            out_valid <= 1'b1;
          end
        end
        S_OUT:  if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// tb/tb_nn_layer_seq.sv - self-checking bench for nn_layer_seq (settle 1 and settle 3 instances)
module tb_nn_layer_seq;

  logic clk = 1'b0;
  logic rst;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [15:0]  a_in_data, a_sample, a_out_data;
  logic [2:0]   a_layer;
  logic [255:0] a_mat, a_l1, a_l2;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [15:0]  b_in_data, b_sample, b_out_data;
  logic [2:0]   b_layer;
  logic [255:0] b_mat, b_l1, b_l2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nn_layer_seq #(.SETTLE_CYCLES(1), .W(16), .N(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .layer(a_layer), .sample(a_sample), .mat_in_vec(a_mat), .l1_vec(a_l1), .l2_vec(a_l2),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  nn_layer_seq #(.SETTLE_CYCLES(3), .W(16), .N(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .layer(b_layer), .sample(b_sample), .mat_in_vec(b_mat), .l1_vec(b_l1), .l2_vec(b_l2),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog observed=timeout expected=finish");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference activation: negative values become floor(x/8) (leaky) or zero
  function automatic logic [15:0] ref_act(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v >= 0) return x;
`ifdef NN_LEAKY_RELU_EN
    v = -((-v + 7) / 8);
    return v[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [255:0] ref_vec(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[16*i +: 16] = ref_act(v[16*i +: 16]);
    return r;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic infer_a(input logic [15:0] x, input logic [255:0] m0, input logic [255:0] m1,
                         input logic [255:0] m2, input int stall, input logic [15:0] pend);
    logic [255:0] e1, e2;
    e1 = ref_vec(m0);
    e2 = ref_vec(m1);
    a_in_valid = 1'b1; a_in_data = x; a_mat = rand_vec();
    tick();
    chk("a_l0_layer", a_layer, 0);
    chk("a_l0_sample", a_sample, x);
    chk("a_l0_ready_busy", {a_in_ready, a_busy}, 2'b01);
    a_in_data = ~x;
    a_mat = m0;
    tick();
    chk("a_l1_layer", a_layer, 1);
    chk("a_l1_vec", a_l1, e1);
    chk("a_busy_sample", a_sample, x);
    a_mat = m1;
    tick();
    chk("a_l2_layer", a_layer, 2);
    chk("a_l2_vec", a_l2, e2);
    chk("a_early_valid", a_out_valid, 0);
    a_mat = m2;
    tick();
    chk("a_out_valid", a_out_valid, 1);
    chk("a_out_data", a_out_data, m2[15:0]);
    chk("a_out_layer", a_layer, 7);
    a_mat = rand_vec(); a_in_data = pend; a_out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("a_hold_data", a_out_data, m2[15:0]);
      chk("a_hold_valid", a_out_valid, 1);
      chk("a_hold_ready", a_in_ready, 0);
      chk("a_hold_sample", a_sample, x);
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("a_done_valid", a_out_valid, 0);
    chk("a_done_ready", a_in_ready, 1);
    chk("a_done_sample", a_sample, x);
    chk("a_done_l1", a_l1, e1);
    chk("a_done_l2", a_l2, e2);
  endtask

  task automatic infer_b(input logic [15:0] x, input logic [255:0] m0, input logic [255:0] m1,
                         input logic [255:0] m2);
    logic [255:0] m;
    b_in_valid = 1'b1; b_in_data = x; b_mat = rand_vec();
    tick();
    b_in_valid = 1'b0;
    chk("b_sample", b_sample, x);
    for (int l = 0; l < 3; l++) begin
      m = (l == 0) ? m0 : (l == 1) ? m1 : m2;
      for (int c = 0; c < 3; c++) begin
        chk("b_layer", b_layer, 256'(l));
        chk("b_early_valid", b_out_valid, 0);
        b_mat = (c == 2) ? m : rand_vec();
        tick();
      end
      if (l == 0) chk("b_l1_vec", b_l1, ref_vec(m0));
      if (l == 1) chk("b_l2_vec", b_l2, ref_vec(m1));
    end
    chk("b_out_valid", b_out_valid, 1);
    chk("b_out_data", b_out_data, m2[15:0]);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("b_done_valid", b_out_valid, 0);
    chk("b_done_ready", b_in_ready, 1);
  endtask

  initial begin
    logic [255:0] m0, m1, m2;
    logic [15:0]  x, nx;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_mat = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_mat = '0; b_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_layer", a_layer, 7);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_vecs", {a_l1 | a_l2}, 0);
    chk("rst_sample_out", {a_sample, a_out_data}, 0);
    chk("rst_b_state", {b_in_ready, b_layer, b_out_valid, b_busy}, 6'b1_111_0_0);

    // Directed basic inference with backpressure
    m0 = '0; m0[15:0] = 16'hFF00; m0[31:16] = 16'h0200;
    m1 = {16{16'h0080}};
    m2 = '0; m2[15:0] = 16'h0340;
    infer_a(16'h0100, m0, m1, m2, 5, 16'h0500);
`ifdef NN_LEAKY_RELU_EN
    chk("basic_l1_e0", a_l1[15:0], 16'hFFE0);
`else
    chk("basic_l1_e0", a_l1[15:0], 16'h0000);
`endif
    chk("basic_l1_e1", a_l1[31:16], 16'h0200);
    chk("basic_l2", a_l2, {16{16'h0080}});

    // Pending 0x0500 accepted next; negative output element passes unrectified
    m2 = rand_vec(); m2[15:0] = 16'h8000;
    x = 16'($urandom);
    infer_a(16'h0500, rand_vec(), rand_vec(), m2, 0, x);
    chk("neg_out_data", a_out_data, 16'h8000);

    for (int i = 0; i < 6; i++) begin
      nx = 16'($urandom);
      infer_a(x, rand_vec(), rand_vec(), rand_vec(), int'($urandom_range(3, 0)), nx);
      x = nx;
    end
    a_in_valid = 1'b0;
    tick();

    // Reset during L1 discards the sample
    m0 = {16{16'h0100}};
    a_in_valid = 1'b1; a_in_data = 16'h0700;
    tick();
    a_in_valid = 1'b0; a_mat = m0;
    tick();
    chk("mid_in_l1", a_layer, 1);
    chk("mid_l1_loaded", a_l1, m0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_layer", a_layer, 7);
    chk("mid_rst_l1", a_l1, 0);
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_ready", a_in_ready, 1);
    chk("mid_rst_sample", a_sample, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_valid", {a_out_valid, a_layer}, 4'b0_111);
    end

    // Reset wins over a simultaneous in_valid
    rst = 1'b1; a_in_valid = 1'b1; a_in_data = 16'h1234;
    tick();
    rst = 1'b0; a_in_valid = 1'b0;
    chk("rst_vs_valid_sample", a_sample, 0);
    chk("rst_vs_valid_idle", {a_in_ready, a_layer}, 4'b1_111);

    // Settle window of 3 cycles per layer
    m2 = rand_vec(); m2[15:0] = 16'h0340;
    infer_b(16'h0100, rand_vec(), rand_vec(), m2);
    infer_b(16'($urandom), rand_vec(), rand_vec(), rand_vec());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_layer_seq.md
Name: nn_layer_seq

Overview:
- Sequencer and activation stage that wraps the 1->16->16->1 layer datapath.
- Accepts one input sample over a valid/ready handshake.
- Steps the datapath's 3-bit layer select through 0, 1, 2.
- After layers 0 and 1, captures the 16-element matrix-multiply result vector, applies ReLU and holds it as l1/l2 activations for the next layer's value operand.
- Returns the raw layer-2 element 0 as the network output over a second valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 1: cycles each layer select is held before its result is captured; legal range 1..15.
- W, 16: element width, signed two's complement Q8.8.
- N, 16: vector length.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  W  input sample, signed Q8.8.
- layer  out  3  layer select to datapath: 0, 1 or 2 while active; 3'd7 otherwise.
- sample  out  W  latched input sample, drives datapath scalar input.
- mat_in_vec  in  N*W  datapath result vector; element i at [16i+15:16i].
- l1_vec  out  N*W  stored layer-1 activations (post-ReLU).
- l2_vec  out  N*W  stored layer-2 activations (post-ReLU).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  network output, signed Q8.8.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; in_ready=1; layer=3'd7; sample, l1_vec, l2_vec, out_data all zero; out_valid=0; busy=0.
- States: IDLE, L0, L1, L2, OUT. A settle counter counts 0..SETTLE_CYCLES-1 inside L0/L1/L2 and clears on every state change.
- IDLE: in_ready=1, layer=7. When in_valid is high: sample<=in_data and go to L0.
- L0: layer=0. On the edge where the counter reaches SETTLE_CYCLES-1: l1_vec[i]<=act(mat_in_vec[i]) for all i, then go to L1.
- L1: layer=1. Same terminal-count rule: l2_vec[i]<=act(mat_in_vec[i]), then go to L2.
- L2: layer=2. At terminal count: out_data<=mat_in_vec element 0, unmodified (no activation on the output layer); out_valid<=1; go to OUT.
- OUT: layer=7. out_valid and out_data are held stable until out_ready. On the out_valid && out_ready edge: out_valid<=0 and go to IDLE.
- in_ready is combinational: (state==IDLE). No sample is accepted in OUT, even in the handshake cycle.
- act(x): ReLU. If x[15]=1 the result is 16'h0000, otherwise x. No saturation is needed, since the output width equals the input width.
- Latency with SETTLE_CYCLES=1: sample accepted at edge T; out_valid is high from edge T+3. In general, out_valid rises 3*SETTLE_CYCLES edges after acceptance.
- sample, l1_vec and l2_vec hold their values between inferences; they are only overwritten at their capture points.
- Reset asserted in any state: everything returns to the reset values on that edge, and any in-flight sample is discarded.
- An in_valid that arrives while busy is ignored. The upstream must hold it until in_ready.
- Simultaneous rst and in_valid: reset wins, and the sample is not latched.

Optional Feature:
- Macro: NN_LEAKY_RELU_EN.
- Defined: act(x) for negative x is x arithmetic-shifted right by 3 (slope 1/8), sign-extended. Example: 0xFF00 (-1.0) -> 0xFFE0 (-0.125).
- Not defined: negative x -> 0x0000.
- Non-negative x passes unchanged in both builds. The output layer is unaffected in both builds.

Test Plan:
- Reset then idle, with SETTLE_CYCLES=1 for all cases unless stated: in_ready=1, layer=7, out_valid=0, all vectors 0, busy=0.
- Basic inference:
  - Stimulus: in_data=0x0100 accepted at T. Bench drives mat_in_vec element0=0xFF00, element1=0x0200 during L0; all elements 0x0080 during L1; element0=0x0340 during L2.
  - Required: layer sequence 0,1,2 on cycles T+1..T+3.
  - Required: l1_vec[0]=0x0000 (leaky build: 0xFFE0), l1_vec[1]=0x0200, l2_vec all 0x0080.
  - Required: out_data=0x0340 with out_valid at T+3.
- Output backpressure: out_ready held low for 5 cycles, with in_valid=1 and in_data=0x0500 throughout.
  - Required: out_data stays 0x0340, in_ready=0, sample stays 0x0100.
  - Required: after out_ready pulses, IDLE resumes and 0x0500 is accepted on the next edge.
- Negative output not rectified: element0=0x8000 in L2 -> out_data=0x8000 in both builds.
- Reset mid-operation: rst asserted during L1.
  - Required: next cycle layer=7, l1_vec=0, out_valid=0, in_ready=1.
  - Required: no out_valid for the aborted sample.
- SETTLE_CYCLES=3: each layer value is held for exactly 3 cycles; out_valid rises 9 edges after acceptance; capture uses the mat_in_vec value from the 3rd cycle of each layer.
